// File: rtl/apb_multi_pad_reader.sv
// APB3 reader for up to NUM_PADS serial game pads that share one latch/clock pair.
// Frames run one-shot or auto-poll, publish an atomic snapshot, and flag completion and changes.
module apb_multi_pad_reader #(
    parameter int NUM_PADS    = 2,
    parameter int BITS        = 8,
    parameter int CLK_DIV     = 2,
    parameter int LATCH_TICKS = 1,
    parameter int POLL_TICKS  = 1000
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic [NUM_PADS-1:0] pad_data,
    output logic                irq
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int LT_W   = $clog2(LATCH_TICKS + 1);
    localparam int BIT_W  = $clog2(BITS);
    localparam int POLL_W = $clog2(POLL_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    state_t                          state_q, state_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [LT_W-1:0]                 lcnt_q, lcnt_d;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [POLL_W-1:0]               poll_q, poll_d;
    logic [NUM_PADS-1:0][BITS-1:0]   shift_q, shift_d;
    logic [NUM_PADS-1:0][BITS-1:0]   data_q, data_d;
    logic en_q, en_d, start_q, start_d, done_en_q, done_en_d;
    logic chg_en_q, chg_en_d, inv_q, inv_d;
    logic done_q, done_d, changed_q, changed_d, irq_q, irq_d;

    logic             tick, busy, apb_wr, sample_en;
    logic             hit_ctrl, hit_stat, hit_pad, mapped;
    logic [BIT_W-1:0] sample_idx;
    logic [31:0]      rd_data, pad_rd;
    logic             unused_wdata;

    assign unused_wdata = ^PWDATA[31:5];

    always_comb begin
        hit_ctrl = (PADDR == 8'h00);
        hit_stat = (PADDR == 8'h04);
        hit_pad  = 1'b0;
        pad_rd   = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (PADDR == 8'(16 + 4 * i)) begin
                hit_pad = 1'b1;
                pad_rd  = 32'(data_q[i]);
            end
        end
        mapped = hit_ctrl | hit_stat | hit_pad;
        apb_wr = PSEL & PENABLE & PWRITE & mapped;
        busy   = (state_q != S_IDLE);

        rd_data = '0;
        if (hit_ctrl)
            rd_data = {27'd0, inv_q, chg_en_q, done_en_q, 1'b0, en_q};
        else if (hit_stat)
            rd_data = {29'd0, changed_q, done_q, busy};
        else if (hit_pad)
            rd_data = pad_rd;
    end

    assign PRDATA    = (PSEL & ~PWRITE) ? rd_data : 32'd0;
    assign PSLVERR   = PSEL & PENABLE & ~mapped;
    assign PREADY    = 1'b1;
    assign pad_latch = (state_q == S_LATCH);
    assign pad_clk   = (state_q == S_HIGH);
    assign irq       = irq_q;

    always_comb begin
        tick       = (div_q == DIV_W'(CLK_DIV - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        state_d    = state_q;
        lcnt_d     = lcnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        poll_d     = poll_q;
        sample_en  = 1'b0;
        sample_idx = '0;
        en_d       = en_q;
        start_d    = start_q;
        done_en_d  = done_en_q;
        chg_en_d   = chg_en_q;
        inv_d      = inv_q;
        done_d     = done_q;
        changed_d  = changed_q;

        // Poll counter saturates so a long-idle EN=1 starts on the very next tick.
        if (tick && poll_q < POLL_W'(POLL_TICKS - 1))
            poll_d = poll_q + 1'b1;

        if (apb_wr && hit_ctrl) begin
            en_d      = PWDATA[0];
            done_en_d = PWDATA[2];
            chg_en_d  = PWDATA[3];
            inv_d     = PWDATA[4];
            if (PWDATA[1] && !busy)
                start_d = 1'b1;
        end
        if (apb_wr && hit_stat) begin
            done_d    = done_q & ~PWDATA[1];
            changed_d = changed_q & ~PWDATA[2];
        end

        case (state_q)
            S_IDLE: begin
                if (tick && (start_q || (en_q && poll_q >= POLL_W'(POLL_TICKS - 1)))) begin
                    state_d = S_LATCH;
                    lcnt_d  = '0;
                    poll_d  = '0;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    if (lcnt_q == LT_W'(LATCH_TICKS - 1)) begin
                        sample_en = 1'b1;
                        bit_d     = BIT_W'(1);
                        state_d   = S_LOW;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (tick)
                    state_d = S_HIGH;
            end
            S_HIGH: begin
                if (tick) begin
                    sample_en  = 1'b1;
                    sample_idx = bit_q;
                    if (bit_q == BIT_W'(BITS - 1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = S_LOW;
                    end
                end
            end
            S_COMMIT: begin
                // Snapshot and status update win over a same-cycle W1C.
                data_d  = shift_q;
                done_d  = 1'b1;
                start_d = 1'b0;
                if (data_q != shift_q)
                    changed_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sample_en) begin
            for (int i = 0; i < NUM_PADS; i++)
                shift_d[i][sample_idx] = pad_data[i] ^ inv_q;
        end

        irq_d = (done_en_q & done_q) | (chg_en_q & changed_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            lcnt_q    <= '0;
            bit_q     <= '0;
            poll_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            done_en_q <= 1'b0;
            chg_en_q  <= 1'b0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            lcnt_q    <= lcnt_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            en_q      <= en_d;
            start_q   <= start_d;
            done_en_q <= done_en_d;
            chg_en_q  <= chg_en_d;
            inv_q     <= inv_d;
            done_q    <= done_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_apb_multi_pad_reader.sv
// Bench for apb_multi_pad_reader: behavioural shift-register pads, APB driver tasks,
// expected-snapshot queue, one task per scenario.
module tb_apb_multi_pad_reader;
    localparam int NUM_PADS = 2;
    localparam int BITS     = 8;
    localparam int W        = NUM_PADS * BITS;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        pad_latch, pad_clk, irq;
    logic [NUM_PADS-1:0] pad_data;

    logic [NUM_PADS-1:0][BITS-1:0] pad_val;
    logic [NUM_PADS-1:0][BITS-1:0] sr;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0, latch_rises = 0, prev_rise = 0, last_rise = 0;
    int clk_pulses = 0, last_clk_fall = 0, latch_hi = 0;
    logic latch_d = 1'b0, clk_d = 1'b0;

    apb_multi_pad_reader #(
        .NUM_PADS(NUM_PADS), .BITS(BITS), .CLK_DIV(2), .LATCH_TICKS(1), .POLL_TICKS(20)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Pad model: parallel load while latched, shift on each rising pad_clk, ones fill in.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch)
            sr = pad_val;
        else
            for (int i = 0; i < NUM_PADS; i++) sr[i] = {1'b1, sr[i][BITS-1:1]};
    end
    assign pad_data = {sr[1][0], sr[0][0]};

    always @(negedge PCLK) begin
        cyc++;
        if (pad_latch && !latch_d) begin
            latch_rises++;
            prev_rise = last_rise;
            last_rise = cyc;
        end
        if (pad_clk && !clk_d) clk_pulses++;
        if (!pad_clk && clk_d) last_clk_fall = cyc;
        if (pad_latch) latch_hi++;
        latch_d = pad_latch;
        clk_d   = pad_clk;
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_pads(output logic [63:0] v);
        logic [31:0] d0, d1;
        logic e;
        apb_read(8'h10, d0, e);
        apb_read(8'h14, d1, e);
        v = {d1, d0};
    endtask

    function automatic logic [63:0] pads_word(input logic [W-1:0] e);
        return {24'd0, e[15:8], 24'd0, e[7:0]};
    endfunction

    task automatic wait_done(output logic [31:0] st);
        logic [31:0] d;
        logic e;
        bit hit;
        hit = 0; st = '0; d = '0;
        for (int k = 0; k < 100 && !hit; k++) begin
            apb_read(8'h04, d, e);
            if (d[1:0] == 2'b10) begin
                hit = 1; st = d;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_done: status=%h, required DONE=1 BUSY=0 within 100 reads", d);
        end
    endtask

    task automatic wait_clk_rise(output bit ok);
        logic prev;
        ok = 0;
        prev = pad_clk;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge PCLK); #1;
            if (pad_clk && !prev) ok = 1;
            prev = pad_clk;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic e;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        n_checks++;
        if ({pad_latch, pad_clk, irq, PREADY} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_outs: latch/clk/irq/ready=%b required 0001", {pad_latch, pad_clk, irq, PREADY});
        end
        n_checks++;
        if (PRDATA !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_prdata_idle: got %h required 0", PRDATA);
        end
        PRESET = 1'b0;
        apb_read(8'h00, d, e);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", d); end
        apb_read(8'h04, d, e);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 0", d); end
    endtask

    task automatic test_one_shot;
        logic [31:0] st, d;
        logic [63:0] v;
        logic [W-1:0] e;
        logic err;
        int r0, p0, h0;
        pad_val = {8'hFF, 8'h8D};
        apb_write(8'h04, 32'h6, err);
        r0 = latch_rises; p0 = clk_pulses; h0 = latch_hi;
        exp_q.push_back(16'hFF8D);
        apb_write(8'h00, 32'h02, err);
        wait_done(st);
        n_checks++;
        if (st !== 32'h6) begin n_fail++; $display("FAIL oneshot_status: got %h required 6", st); end
        n_checks++;
        if (latch_rises - r0 != 1 || clk_pulses - p0 != 7 || latch_hi - h0 != 2) begin
            n_fail++;
            $display("FAIL oneshot_pulses: latch=%0d clk=%0d latch_cycles=%0d required 1 7 2",
                     latch_rises - r0, clk_pulses - p0, latch_hi - h0);
        end
        n_checks++;
        if (last_clk_fall - last_rise != 30) begin
            n_fail++;
            $display("FAIL oneshot_frame_len: got %0d PCLK required 30", last_clk_fall - last_rise);
        end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL oneshot_data: got %h required %h", v, pads_word(e)); end
        apb_read(8'h00, d, err);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL start_reads_0: got %h required 0", d); end
    endtask

    task automatic test_invert;
        logic [31:0] st;
        logic [63:0] v;
        logic [W-1:0] e;
        logic err;
        apb_write(8'h04, 32'h6, err);
        exp_q.push_back(16'h0072);
        apb_write(8'h00, 32'h12, err);
        wait_done(st);
        n_checks++;
        if (st[2] !== 1'b1) begin n_fail++; $display("FAIL invert_changed: got %b required 1", st[2]); end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL invert_data: got %h required %h", v, pads_word(e)); end
    endtask

    task automatic test_irq;
        logic [31:0] st, d;
        logic [63:0] v;
        logic [W-1:0] e;
        logic err;
        bit ok;
        apb_write(8'h04, 32'h6, err);
        repeat (2) @(posedge PCLK);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", irq); end
        exp_q.push_back(pad_val);
        apb_write(8'h00, 32'h06, err);
        wait_done(st);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_done: got %b required 1", irq); end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL irq_data: got %h required %h", v, pads_word(e)); end
        // Second frame: W1C of DONE lands on the COMMIT edge (3 PCLK after the 7th pad_clk rise).
        apb_write(8'h00, 32'h06, err);
        for (int k = 0; k < 7; k++) wait_clk_rise(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL irq_clk_rise: got timeout required 7 pad_clk pulses"); end
        apb_write(8'h04, 32'h2, err);
        apb_read(8'h04, d, err);
        n_checks++;
        if (d[1:0] !== 2'b10) begin n_fail++; $display("FAIL w1c_vs_commit: DONE/BUSY=%b required 10", d[1:0]); end
        apb_write(8'h04, 32'h2, err);
        apb_read(8'h04, d, err);
        n_checks++;
        if (d[1] !== 1'b0) begin n_fail++; $display("FAIL w1c_done: got %b required 0", d[1]); end
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b required 0", irq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] st;
        logic [63:0] v;
        logic [W-1:0] e;
        logic err;
        int r0, k;
        pad_val = {8'h5A, 8'hC3};
        apb_write(8'h04, 32'h6, err);
        r0 = latch_rises;
        exp_q.push_back(pad_val);
        apb_write(8'h00, 32'h02, err);
        k = 0;
        while (!pad_latch && k < 20) begin @(posedge PCLK); #1; k++; end
        apb_write(8'h00, 32'h02, err);
        wait_done(st);
        repeat (80) @(posedge PCLK);
        n_checks++;
        if (latch_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: frames=%0d required 1", latch_rises - r0);
        end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL b2b_data: got %h required %h", v, pads_word(e)); end
    endtask

    task automatic test_apb_err;
        logic [31:0] d;
        logic err;
        apb_read(8'h18, d, err);
        n_checks++;
        if ({err, d} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL unmapped_read: err=%b data=%h required err=1 data=0", err, d);
        end
        apb_read(8'h14, d, err);
        n_checks++;
        if ({err, d} !== {1'b0, 32'h5A}) begin
            n_fail++;
            $display("FAIL data1_read: err=%b data=%h required err=0 data=5a", err, d);
        end
        apb_write(8'h08, 32'hFFFF_FFFF, err);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_write: err=%b required 1", err); end
        apb_read(8'h00, d, err);
        n_checks++;
        if ({err, d} !== 33'd0) begin n_fail++; $display("FAIL ctrl_untouched: err=%b data=%h required 0 0", err, d); end
    endtask

    task automatic test_auto_poll;
        logic [31:0] st;
        logic [63:0] v;
        logic [W-1:0] e;
        logic err;
        int r0, r1, k;
        pad_val = {8'hA5, 8'h3C};
        apb_write(8'h04, 32'h6, err);
        r0 = latch_rises;
        exp_q.push_back(pad_val);
        exp_q.push_back(pad_val);
        apb_write(8'h00, 32'h01, err);
        wait_done(st);
        n_checks++;
        if (st[2] !== 1'b1) begin n_fail++; $display("FAIL auto_changed_first: got %b required 1", st[2]); end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL auto_data1: got %h required %h", v, pads_word(e)); end
        apb_write(8'h04, 32'h6, err);
        k = 0;
        while (latch_rises - r0 < 2 && k < 200) begin @(posedge PCLK); k++; end
        n_checks++;
        if (last_rise - prev_rise != 40) begin
            n_fail++;
            $display("FAIL auto_period: got %0d PCLK required 40", last_rise - prev_rise);
        end
        wait_done(st);
        n_checks++;
        if (st[2] !== 1'b0) begin n_fail++; $display("FAIL auto_changed_steady: got %b required 0", st[2]); end
        read_pads(v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== pads_word(e)) begin n_fail++; $display("FAIL auto_data2: got %h required %h", v, pads_word(e)); end
        apb_write(8'h00, 32'h00, err);
        k = 0;
        st = 32'h1;
        while (st[0] && k < 50) begin apb_read(8'h04, st, err); k++; end
        r1 = latch_rises;
        repeat (100) @(posedge PCLK);
        n_checks++;
        if (latch_rises != r1) begin n_fail++; $display("FAIL auto_stop: frames=%0d required 0", latch_rises - r1); end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] v;
        logic [31:0] d;
        logic err;
        bit ok;
        pad_val = {8'h22, 8'h11};
        apb_write(8'h00, 32'h0E, err);
        wait_clk_rise(ok);
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if ({ok, pad_latch, pad_clk, irq} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midframe_reset_outs: ok/latch/clk/irq=%b required 1000", {ok, pad_latch, pad_clk, irq});
        end
        @(posedge PCLK); #3;
        PRESET = 1'b0;
        read_pads(v);
        n_checks++;
        if (v !== 64'd0) begin n_fail++; $display("FAIL midframe_data: got %h required 0", v); end
        apb_read(8'h04, d, err);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL midframe_status: got %h required 0", d); end
        repeat (60) @(posedge PCLK);
        apb_read(8'h04, d, err);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL midframe_no_resume: got %h required 0", d); end
    endtask

    initial begin
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        pad_val = '0; sr = '0;
        test_reset;
        test_one_shot;
        test_invert;
        test_irq;
        test_back_to_back;
        test_apb_err;
        test_auto_poll;
        test_reset_mid_frame;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_multi_pad_reader.md
Name: apb_multi_pad_reader

Overview:
APB3 peripheral that reads up to NUM_PADS Nintendo-style serial controllers over one shared latch/clock pair, with one data input per pad. It generalises the single-pad 8-bit reader:
- parametrised pad count and bit count (NES 8 / SNES 16);
- programmable divider, one-shot or auto-poll mode;
- atomic multi-pad snapshot, change detection and interrupt.

It sits on the APB3 fabric beside the other game peripherals; firmware polls registers or takes irq.

Parameters:
NUM_PADS, 2, number of pads, 1..4
BITS, 8, bits shifted per pad per frame, 8 or 16
CLK_DIV, 2, PCLK cycles per tick, >=2
LATCH_TICKS, 1, ticks pad_latch is held high, >=1
POLL_TICKS, 1000, ticks between frame starts in auto mode, >= LATCH_TICKS+2*(BITS-1)+1

Ports:
PCLK  in  1  single system clock, rising edge
PRESET  in  1  asynchronous, active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write when 1
PADDR  in  8  APB byte address
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  error on unmapped access
pad_latch  out  1  shared latch to all pads
pad_clk  out  1  shared serial clock to all pads
pad_data  in  NUM_PADS  serial data, bit i from pad i
irq  out  1  level interrupt

Behaviour:
- Reset (async, PRESET=1): pad_latch=0, pad_clk=0, irq=0, all registers 0, FSM IDLE, divider and poll counters 0. Applies immediately mid-frame; partial frame discarded.
- Tick: one-PCLK pulse every CLK_DIV cycles from a free-running divider. FSM advances only on tick, except COMMIT.
- Register map:
  - 0x00 CTRL, RW: b0 EN (auto poll), b1 START (write-1 one-shot, reads 0), b2 IRQ_DONE_EN, b3 IRQ_CHG_EN, b4 INVERT.
  - 0x04 STATUS: b0 BUSY (RO), b1 DONE (sticky, W1C), b2 CHANGED (sticky, W1C).
  - 0x10+4*i DATA[i], RO, i<NUM_PADS: [BITS-1:0] pad value, upper bits 0.
- APB access:
  - Write commits on the PCLK edge with PSEL&PENABLE&PWRITE.
  - PRDATA is combinational, valid when PSEL&~PWRITE, 0 otherwise.
  - PSLVERR=1 during the access phase for any unmapped address, including DATA beyond NUM_PADS-1; such writes have no effect.
- FSM states: IDLE, LATCH, LOW, HIGH, COMMIT.
  - IDLE: go to LATCH on tick if START pending or (EN and poll counter >= POLL_TICKS-1). Poll counter counts ticks, restarts at 0 on LATCH entry.
  - LATCH: pad_latch=1 for LATCH_TICKS ticks. On exit, sample bit 0 of every pad and go to LOW.
  - LOW: pad_clk=0 for 1 tick, then go to HIGH.
  - HIGH: pad_clk=1 for 1 tick. On exit, sample the next bit. Go to COMMIT after bit BITS-1, else LOW.
- Bit order: first sampled bit goes to DATA bit 0. Sampled bit = pad_data[i] XOR INVERT.
- COMMIT, one PCLK:
  - DATA[all] updated atomically.
  - CHANGED set if any DATA differs from its prior value.
  - DONE set, START pending cleared, return to IDLE.
- Frame length: LATCH_TICKS+2*(BITS-1) ticks, plus 1 PCLK for COMMIT. BUSY=1 in every state except IDLE.
- START behaviour:
  - Written during BUSY: ignored, no queueing.
  - Written in IDLE: pending until the next tick.
- Clearing EN mid-frame: the frame completes.
- W1C of DONE/CHANGED in the same cycle as COMMIT sets it: set wins.
- irq = (IRQ_DONE_EN & DONE) | (IRQ_CHG_EN & CHANGED), registered.

Test Plan:
- Reset: PRESET pulse mid-frame -> pad_latch=0, pad_clk=0 immediately; DATA/STATUS read 0.
- One-shot (NUM_PADS=2, BITS=8, CLK_DIV=2, LATCH_TICKS=1): write CTRL=0x02; pad0 streams 1,0,1,1,0,0,0,1, pad1 all 1 -> DATA0=0x8D, DATA1=0xFF, DONE=1, CHANGED=1. Frame is 15 ticks (30 PCLK) + COMMIT, with 1 latch tick and 7 pad_clk pulses.
- INVERT=1 with the same stream -> DATA0=0x72, DATA1=0x00.
- Auto poll with EN=1, POLL_TICKS=20, constant input -> latch rising edges 20 ticks apart. CHANGED set only after the first frame (W1C it); stays 0 while input is unchanged.
- irq: IRQ_DONE_EN=1 -> irq rises after COMMIT. W1C DONE in the same cycle as the next COMMIT -> DONE stays 1.
- APB: read 0x18 with NUM_PADS=2 -> PSLVERR=1, PRDATA=0. START written while BUSY -> exactly one frame occurs.
